mem_access_stage: RTL and testbench

//  MEM-stage data memory for the pipelined MIPS core; sits between the EX/MEM register and the MEM/WB register.

---
 rtl/mem_access_stage.sv | 80 ++++++++
 tb/tb_mem_access_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// mem_access_stage: MEM-stage data RAM with byte/half/word loads and stores.
// A LATENCY-cycle counter FSM raises stallM until the access completes.
module mem_access_stage #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memreadM,
   input  logic        memwriteM,
   input  logic [1:0]  memsizeM,
   input  logic        memsignedM,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        misalignM
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = LATENCY > 2 ? $clog2(LATENCY) : 1;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [31:0]   ram [DEPTH];
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic [31:0]   word, lane, wmask, wdata;
   logic          req, access, done, unused_bits;

   assign idx         = aluoutM[AW+1:2];
   assign off         = aluoutM[1:0];
   assign unused_bits = ^aluoutM[31:AW+2];
   assign req         = memreadM | memwriteM;
   assign misalignM   = rst_n & req & (memsizeM == 2'b01 ? off[0] : memsizeM[1] & (off != 2'b00));
   assign access      = rst_n & req & ~misalignM;
   assign done        = access & (state == WAIT ? cnt == '0 : LATENCY == 1);
   assign stallM      = access & ~done;
   assign word        = ram[idx];
   assign lane        = word >> {off, 3'b000};

   always_comb begin
      readdataM = 32'h0;
      if (access & memreadM & ~memwriteM)
         readdataM = memsizeM == 2'b00 ? {{24{memsignedM & lane[7]}}, lane[7:0]} :
                     memsizeM == 2'b01 ? {{16{memsignedM & lane[15]}}, lane[15:0]} : word;
   end

   // Store data replicated across lanes; the byte-enable mask picks the live lane.
   assign wmask = memsizeM == 2'b00 ? 32'hFF << {off, 3'b000} :
                  memsizeM == 2'b01 ? 32'hFFFF << {off, 3'b000} : 32'hFFFF_FFFF;
   assign wdata = memsizeM == 2'b00 ? {4{writedataM[7:0]}} :
                  memsizeM == 2'b01 ? {2{writedataM[15:0]}} : writedataM;

   always_ff @(posedge clk)
      if (done & memwriteM) ram[idx] <= (word & ~wmask) | (wdata & wmask);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == IDLE) begin
         if (access && LATENCY > 1) begin
            state_nx = WAIT;
            cnt_nx   = CW'(LATENCY - 2);
         end
      end else if (cnt == '0) state_nx = IDLE;
      else cnt_nx = cnt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
// tb_mem_access_stage: directed vectors plus random accesses against a byte-array model,
// on one LATENCY=1 and one LATENCY=3 instance sharing the input bus.
module tb_mem_access_stage;
   localparam int DEPTH = 256;
   localparam int NB    = DEPTH * 4;

   logic        clk = 0, rst_n = 0, sel = 0, rd = 0, wr = 0, sg = 0;
   logic [1:0]  sz = 0;
   logic [31:0] addr = 0, wd = 0;
   logic [31:0] rd1, rd3;
   logic        st1, st3, mi1, mi3;
   int          errs = 0, checks = 0;
   logic [7:0]  mem [2][NB];

   always #5 clk = ~clk;

   mem_access_stage #(.DEPTH(DEPTH), .LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .memreadM(rd & ~sel), .memwriteM(wr & ~sel),
      .memsizeM(sz), .memsignedM(sg), .aluoutM(addr), .writedataM(wd),
      .readdataM(rd1), .stallM(st1), .misalignM(mi1));

   mem_access_stage #(.DEPTH(DEPTH), .LATENCY(3)) u3 (
      .clk(clk), .rst_n(rst_n), .memreadM(rd & sel), .memwriteM(wr & sel),
      .memsizeM(sz), .memsignedM(sg), .aluoutM(addr), .writedataM(wd),
      .readdataM(rd3), .stallM(st3), .misalignM(mi3));

   typedef struct {
      logic        r, w;
      logic [1:0]  z;
      logic        g;
      logic [31:0] a, d, q;
      logic        m;
   } vec_t;
   vec_t tv[$];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic logic is_mis(input logic [1:0] z, input logic [31:0] a);
      return z == 2'b01 ? a[0] : z[1] && a[1:0] != 2'b00;
   endfunction

   function automatic logic [31:0] mload(input int s, input logic [1:0] z, input logic g, input logic [31:0] a);
      int b = int'(a % NB);
      logic [7:0] b0 = mem[s][b];
      logic [15:0] h = {mem[s][(b + 1) % NB], b0};
      if (z == 2'b00) return g ? {{24{b0[7]}}, b0} : {24'h0, b0};
      if (z == 2'b01) return g ? {{16{h[15]}}, h} : {16'h0, h};
      return {mem[s][(b + 3) % NB], mem[s][(b + 2) % NB], h};
   endfunction

   task automatic mstore(input int s, input logic [1:0] z, input logic [31:0] a, input logic [31:0] d);
      int n = z == 2'b00 ? 1 : z == 2'b01 ? 2 : 4;
      for (int i = 0; i < n; i++) mem[s][(int'(a % NB) + i) % NB] = d[8*i +: 8];
   endtask

   // One access: drive at negedge, count stall cycles, capture result in the completing cycle.
   task automatic do_acc(input bit s, input logic r, input logic w, input logic [1:0] z, input logic g,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q, output int ns, output logic m);
      @(negedge clk);
      sel = s; rd = r; wr = w; sz = z; sg = g; addr = a; wd = d;
      ns = 0; q = 'x; m = 'x;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (!(s ? st3 : st1)) begin
            q = s ? rd3 : rd1;
            m = s ? mi3 : mi1;
            break;
         end
         ns++;
         @(negedge clk);
      end
      if (ns >= 20) begin
         errs++; checks++;
         $display("FAIL timeout: stallM held %0d cycles, required release", ns);
      end else @(posedge clk);
   endtask

   task automatic add(input logic r, input logic w, input logic [1:0] z, input logic g,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] q, input logic m);
      vec_t v;
      v.r = r; v.w = w; v.z = z; v.g = g; v.a = a; v.d = d; v.q = q; v.m = m;
      tv.push_back(v);
   endtask

   initial begin
      logic [31:0] q, exp_q;
      logic        m, exp_m, r, w, g;
      logic [1:0]  z;
      logic [31:0] a, d;
      int          ns, lat;

      add(0, 1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
      add(1, 0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
      add(0, 1, 2'd0, 0, 32'h13,  32'h12345680, 32'h0,        0);
      add(1, 0, 2'd0, 1, 32'h13,  32'h0,        32'hFFFFFF80, 0);
      add(1, 0, 2'd0, 0, 32'h13,  32'h0,        32'h00000080, 0);
      add(1, 0, 2'd2, 0, 32'h10,  32'h0,        32'h80ADBEEF, 0);
      add(1, 0, 2'd1, 0, 32'h12,  32'h0,        32'h000080AD, 0);
      add(1, 0, 2'd1, 1, 32'h12,  32'h0,        32'hFFFF80AD, 0);
      add(0, 1, 2'd1, 0, 32'h11,  32'h0000FFFF, 32'h0,        1);
      add(1, 0, 2'd2, 0, 32'h12,  32'h0,        32'h0,        1);
      add(1, 0, 2'd2, 1, 32'h10,  32'h0,        32'h80ADBEEF, 0);
      add(1, 0, 2'd3, 1, 32'h10,  32'h0,        32'h80ADBEEF, 0);
      add(0, 1, 2'd2, 0, 32'h400, 32'hCAFEF00D, 32'h0,        0);
      add(1, 0, 2'd2, 0, 32'h000, 32'h0,        32'hCAFEF00D, 0);
      add(1, 1, 2'd0, 0, 32'h21,  32'hAB,       32'h0,        0);
      add(1, 0, 2'd0, 0, 32'h21,  32'h0,        32'h000000AB, 0);

      // Reset state with requests pending on both instances.
      sel = 1; rd = 1; sz = 2'd2; addr = 32'h0;
      #12;
      chk("reset stallM", {31'h0, st3}, 32'h0);
      chk("reset readdataM", rd3, 32'h0);
      sel = 0; addr = 32'h2;
      #1;
      chk("reset misalignM", {31'h0, mi1}, 32'h0);
      rd = 0;
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < DEPTH; i++)
         for (int s = 0; s < 2; s++) begin
            d = $urandom;
            do_acc(s[0], 0, 1, 2'd2, 0, i * 4, d, q, ns, m);
            mstore(s, 2'd2, i * 4, d);
         end

      foreach (tv[i]) begin
         do_acc(0, tv[i].r, tv[i].w, tv[i].z, tv[i].g, tv[i].a, tv[i].d, q, ns, m);
         chk($sformatf("vec%0d readdataM", i), q, tv[i].q);
         chk($sformatf("vec%0d misalignM", i), {31'h0, m}, {31'h0, tv[i].m});
         chk($sformatf("vec%0d stall cycles", i), ns, 0);
         if (tv[i].w && !tv[i].m) mstore(0, tv[i].z, tv[i].a, tv[i].d);
      end

      // LATENCY=3: two back-to-back loads each stall exactly 2 cycles.
      do_acc(1, 1, 0, 2'd2, 0, 32'h10, 0, q, ns, m);
      chk("lat3 lw1 stall cycles", ns, 2);
      chk("lat3 lw1 data", q, mload(1, 2'd2, 0, 32'h10));
      do_acc(1, 1, 0, 2'd2, 0, 32'h14, 0, q, ns, m);
      chk("lat3 lw2 stall cycles", ns, 2);
      chk("lat3 lw2 data", q, mload(1, 2'd2, 0, 32'h14));

      // Reset during the second stall cycle of a store: store must be discarded.
      @(negedge clk);
      sel = 1; rd = 0; wr = 1; sz = 2'd2; addr = 32'h20; wd = 32'h12345678;
      #1 chk("rst-mid stall 1", {31'h0, st3}, 32'h1);
      @(negedge clk);
      #1 chk("rst-mid stall 2", {31'h0, st3}, 32'h1);
      rst_n = 0;
      #1 chk("rst-mid stall drop", {31'h0, st3}, 32'h0);
      @(negedge clk);
      wr = 0; rst_n = 1;
      do_acc(1, 1, 0, 2'd2, 0, 32'h20, 0, q, ns, m);
      chk("rst-mid old value", q, mload(1, 2'd2, 0, 32'h20));
      chk("rst-mid reload stalls", ns, 2);

      for (int s = 0; s < 2; s++) begin
         lat = s ? 3 : 1;
         for (int i = 0; i < 150; i++) begin
            r = 1'($urandom_range(0, 1));
            w = r ? ($urandom_range(0, 3) == 0) : 1'b1;
            z = 2'($urandom_range(0, 3));
            g = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 2047);
            d = $urandom;
            exp_m = is_mis(z, a);
            exp_q = (r && !w && !exp_m) ? mload(s, z, g, a) : 32'h0;
            do_acc(s[0], r, w, z, g, a, d, q, ns, m);
            chk($sformatf("rnd L%0d #%0d readdataM", lat, i), q, exp_q);
            chk($sformatf("rnd L%0d #%0d misalignM", lat, i), {31'h0, m}, {31'h0, exp_m});
            chk($sformatf("rnd L%0d #%0d stall cycles", lat, i), ns, exp_m ? 0 : lat - 1);
            if (w && !exp_m) mstore(s, z, a, d);
         end
      end

      @(negedge clk);
      rd = 0; wr = 0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
